// File: rtl/cpu_sequencer.sv
// Eight-phase fetch/decode/execute control sequencer for the 8-bit accumulator CPU.
// Control strobes are pure combinational decodes of the state, opcode and zero flag.
module cpu_sequencer #(
    parameter int OPW = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    input  logic           go,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    output logic           sel,
    output logic           rd,
    output logic           ld_ir,
    output logic           inc_pc,
    output logic           halt,
    output logic           ld_pc,
    output logic           data_e,
    output logic           ld_ac,
    output logic           wr,
    output logic [3:0]     phase
);

    typedef enum logic [3:0] {
        INST_ADDR  = 4'd0,
        INST_FETCH = 4'd1,
        INST_LOAD  = 4'd2,
        IDLE       = 4'd3,
        OP_ADDR    = 4'd4,
        OP_FETCH   = 4'd5,
        ALU_OP     = 4'd6,
        STORE      = 4'd7,
        HALTED     = 4'd8
    } state_t;

    localparam logic [OPW-1:0] OP_HLT = OPW'(0);
    localparam logic [OPW-1:0] OP_SKZ = OPW'(1);
    localparam logic [OPW-1:0] OP_ADD = OPW'(2);
    localparam logic [OPW-1:0] OP_AND = OPW'(3);
    localparam logic [OPW-1:0] OP_XOR = OPW'(4);
    localparam logic [OPW-1:0] OP_LDA = OPW'(5);
    localparam logic [OPW-1:0] OP_STO = OPW'(6);
    localparam logic [OPW-1:0] OP_JMP = OPW'(7);

    // Kept as a plain 4-bit vector so the unused codes 9-15 are representable.
    logic [3:0] state;
    logic [3:0] state_next;
    logic       alu_op;

    assign alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);
    assign phase  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INST_ADDR;
        end else begin
            state <= state_next;
        end
    end

    // HALTED resumes on go regardless of enable; illegal codes recover unconditionally.
    always_comb begin
        state_next = state;
        case (state)
            INST_ADDR:  if (enable) state_next = INST_FETCH;
            INST_FETCH: if (enable) state_next = INST_LOAD;
            INST_LOAD:  if (enable) state_next = IDLE;
            IDLE:       if (enable) state_next = OP_ADDR;
            OP_ADDR:    if (enable) state_next = (opcode == OP_HLT) ? HALTED : OP_FETCH;
            OP_FETCH:   if (enable) state_next = ALU_OP;
            ALU_OP:     if (enable) state_next = STORE;
            STORE:      if (enable) state_next = INST_ADDR;
            HALTED:     if (go)     state_next = OP_FETCH;
            default:    state_next = INST_ADDR;
        endcase
    end

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        halt   = 1'b0;
        ld_pc  = 1'b0;
        data_e = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        case (state)
            INST_ADDR: begin
                sel = 1'b1;
            end
            INST_FETCH: begin
                sel = 1'b1;
                rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
                sel   = 1'b1;
                rd    = 1'b1;
                ld_ir = 1'b1;
            end
            OP_ADDR: begin
                inc_pc = 1'b1;
                halt   = (opcode == OP_HLT);
            end
            OP_FETCH: begin
                rd = alu_op;
            end
            ALU_OP: begin
                rd     = alu_op;
                inc_pc = (opcode == OP_SKZ) && zero;
                ld_pc  = (opcode == OP_JMP);
                data_e = (opcode == OP_STO);
            end
            STORE: begin
                rd     = alu_op;
                ld_ac  = alu_op;
                ld_pc  = (opcode == OP_JMP);
                wr     = (opcode == OP_STO);
                data_e = (opcode == OP_STO);
            end
            HALTED: begin
                halt = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: directed per-cycle vectors push expected
// phase/strobe words; an independent monitor pops and compares them.
module tb_cpu_sequencer;

    localparam logic [2:0] HLT = 3'd0;
    localparam logic [2:0] SKZ = 3'd1;
    localparam logic [2:0] ADD = 3'd2;
    localparam logic [2:0] STO = 3'd6;
    localparam logic [2:0] JMP = 3'd7;

    // Strobe word order: sel rd ld_ir | inc_pc halt ld_pc | data_e ld_ac wr
    localparam logic [8:0] S_NONE = 9'b000_000_000;
    localparam logic [8:0] S_IA   = 9'b100_000_000;
    localparam logic [8:0] S_IF   = 9'b110_000_000;
    localparam logic [8:0] S_IL   = 9'b111_000_000;
    localparam logic [8:0] S_OA   = 9'b000_100_000;
    localparam logic [8:0] S_OAH  = 9'b000_110_000;
    localparam logic [8:0] S_HALT = 9'b000_010_000;
    localparam logic [8:0] S_RD   = 9'b010_000_000;
    localparam logic [8:0] S_ACC  = 9'b010_000_010;
    localparam logic [8:0] S_DE   = 9'b000_000_100;
    localparam logic [8:0] S_WR   = 9'b000_000_101;
    localparam logic [8:0] S_JMP  = 9'b000_001_000;
    localparam logic [8:0] S_SKIP = 9'b000_100_000;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       go;
        logic [2:0] op;
        logic       zero;
        logic       noclk;
        logic [3:0] ph;
        logic [8:0] str;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic       go = 1'b0;
    logic [2:0] opcode = ADD;
    logic       zero = 1'b0;
    logic       sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
    logic [3:0] phase;

    vec_t        vecs[$];
    logic [12:0] exp_q[$];
    int          idx_q[$];
    int          checks = 0;
    int          errors = 0;
    event        check_ev;

    cpu_sequencer #(.OPW(3)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .go     (go),
        .opcode (opcode),
        .zero   (zero),
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .halt   (halt),
        .ld_pc  (ld_pc),
        .data_e (data_e),
        .ld_ac  (ld_ac),
        .wr     (wr),
        .phase  (phase)
    );

    always #5 clk = ~clk;

    function automatic void v(input logic r, input logic e, input logic g, input logic [2:0] o,
                              input logic z, input logic nc, input logic [3:0] p, input logic [8:0] s);
        vec_t t;
        t.rst_n = r; t.en = e; t.go = g; t.op = o; t.zero = z; t.noclk = nc; t.ph = p; t.str = s;
        vecs.push_back(t);
    endfunction

    function automatic void fetch_vecs(input logic [2:0] o);
        v(1, 1, 0, o, 0, 0, 4'd0, S_IA);
        v(1, 1, 0, o, 0, 0, 4'd1, S_IF);
        v(1, 1, 0, o, 0, 0, 4'd2, S_IL);
        v(1, 1, 0, o, 0, 0, 4'd3, S_IL);
    endfunction

    task automatic apply_stimulus(input vec_t t, input int idx);
        rst_n  = t.rst_n;
        enable = t.en;
        go     = t.go;
        opcode = t.op;
        zero   = t.zero;
        exp_q.push_back({t.ph, t.str});
        idx_q.push_back(idx);
        -> check_ev;
        if (t.noclk) #2;
        else begin
            @(posedge clk);
            #2;
        end
    endtask

    // Monitor: samples 1 time unit after each stimulus, well clear of clock edges.
    initial begin : monitor
        logic [12:0] got;
        logic [12:0] want;
        int          idx;
        forever begin
            @(check_ev);
            #1;
            got = {phase, sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_sample: got ph=%0d str=%b, no expected entry", got[12:9], got[8:0]);
            end else begin
                want = exp_q.pop_front();
                idx  = idx_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("[TB] FAIL vec%0d: got ph=%0d str=%b, expected ph=%0d str=%b",
                             idx, got[12:9], got[8:0], want[12:9], want[8:0]);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        // Reset, free-run, then asynchronous reset mid phase 5
        v(0, 1, 0, ADD, 0, 0, 4'd0, S_IA);
        v(1, 1, 0, ADD, 0, 0, 4'd0, S_IA);
        v(1, 1, 0, ADD, 0, 0, 4'd1, S_IF);
        v(1, 1, 0, ADD, 0, 0, 4'd2, S_IL);
        v(1, 1, 0, ADD, 0, 0, 4'd3, S_IL);
        v(1, 1, 0, ADD, 0, 0, 4'd4, S_OA);
        v(1, 1, 0, ADD, 0, 1, 4'd5, S_RD);
        v(0, 1, 0, ADD, 0, 0, 4'd0, S_IA);
        v(1, 1, 0, ADD, 0, 0, 4'd0, S_IA);
        v(1, 1, 0, ADD, 0, 0, 4'd1, S_IF);
        v(1, 1, 0, ADD, 0, 0, 4'd2, S_IL);
        v(1, 1, 0, ADD, 0, 0, 4'd3, S_IL);
        v(1, 1, 0, ADD, 0, 0, 4'd4, S_OA);
        v(1, 1, 0, ADD, 0, 0, 4'd5, S_RD);
        v(1, 1, 0, ADD, 0, 0, 4'd6, S_RD);
        v(1, 1, 0, ADD, 0, 0, 4'd7, S_ACC);
        // STO
        fetch_vecs(STO);
        v(1, 1, 0, STO, 0, 0, 4'd4, S_OA);
        v(1, 1, 0, STO, 0, 0, 4'd5, S_NONE);
        v(1, 1, 0, STO, 0, 0, 4'd6, S_DE);
        v(1, 1, 0, STO, 0, 0, 4'd7, S_WR);
        // JMP
        fetch_vecs(JMP);
        v(1, 1, 0, JMP, 0, 0, 4'd4, S_OA);
        v(1, 1, 0, JMP, 0, 0, 4'd5, S_NONE);
        v(1, 1, 0, JMP, 0, 0, 4'd6, S_JMP);
        v(1, 1, 0, JMP, 0, 0, 4'd7, S_JMP);
        // SKZ taken, then not taken (zero only matters in phase 6)
        fetch_vecs(SKZ);
        v(1, 1, 0, SKZ, 0, 0, 4'd4, S_OA);
        v(1, 1, 0, SKZ, 0, 0, 4'd5, S_NONE);
        v(1, 1, 0, SKZ, 1, 0, 4'd6, S_SKIP);
        v(1, 1, 0, SKZ, 1, 0, 4'd7, S_NONE);
        fetch_vecs(SKZ);
        v(1, 1, 0, SKZ, 0, 0, 4'd4, S_OA);
        v(1, 1, 0, SKZ, 1, 0, 4'd5, S_NONE);
        v(1, 1, 0, SKZ, 0, 0, 4'd6, S_NONE);
        v(1, 1, 0, SKZ, 1, 0, 4'd7, S_NONE);
        // HLT, wait 5 cycles, resume with go while enable is low
        fetch_vecs(HLT);
        v(1, 1, 0, HLT, 0, 0, 4'd4, S_OAH);
        for (int i = 0; i < 5; i++) v(1, 1, 0, HLT, 0, 0, 4'd8, S_HALT);
        v(1, 0, 1, HLT, 0, 0, 4'd8, S_HALT);
        v(1, 1, 0, HLT, 0, 0, 4'd5, S_NONE);
        v(1, 1, 0, HLT, 0, 0, 4'd6, S_NONE);
        v(1, 1, 0, HLT, 0, 0, 4'd7, S_NONE);
        // HLT with go already high: exactly one HALTED cycle
        fetch_vecs(HLT);
        v(1, 1, 1, HLT, 0, 0, 4'd4, S_OAH);
        v(1, 1, 1, HLT, 0, 0, 4'd8, S_HALT);
        v(1, 1, 0, HLT, 0, 0, 4'd5, S_NONE);
        v(1, 1, 0, HLT, 0, 0, 4'd6, S_NONE);
        v(1, 1, 0, HLT, 0, 0, 4'd7, S_NONE);
        // Reset while halted
        fetch_vecs(HLT);
        v(1, 1, 0, HLT, 0, 0, 4'd4, S_OAH);
        v(1, 1, 0, HLT, 0, 1, 4'd8, S_HALT);
        v(0, 1, 0, HLT, 0, 0, 4'd0, S_IA);
        v(1, 1, 0, ADD, 0, 0, 4'd0, S_IA);
        // Stalls in phases 2, 6 and 7 with opcode/zero changing mid-stall
        v(1, 1, 0, ADD, 0, 0, 4'd1, S_IF);
        v(1, 0, 0, ADD, 0, 0, 4'd2, S_IL);
        v(1, 0, 0, STO, 0, 0, 4'd2, S_IL);
        v(1, 0, 0, JMP, 0, 0, 4'd2, S_IL);
        v(1, 1, 0, ADD, 0, 0, 4'd2, S_IL);
        v(1, 1, 0, ADD, 0, 0, 4'd3, S_IL);
        v(1, 1, 0, ADD, 0, 0, 4'd4, S_OA);
        v(1, 1, 0, ADD, 0, 0, 4'd5, S_RD);
        v(1, 0, 0, SKZ, 0, 0, 4'd6, S_NONE);
        v(1, 0, 0, SKZ, 1, 0, 4'd6, S_SKIP);
        v(1, 1, 0, ADD, 0, 0, 4'd6, S_RD);
        v(1, 0, 0, ADD, 0, 0, 4'd7, S_ACC);
        v(1, 0, 0, STO, 0, 0, 4'd7, S_WR);
        v(1, 0, 0, JMP, 0, 0, 4'd7, S_JMP);
        v(1, 1, 0, ADD, 0, 0, 4'd7, S_ACC);
        v(1, 1, 0, ADD, 0, 0, 4'd0, S_IA);

        #2;
        for (int i = 0; i < vecs.size(); i++) apply_stimulus(vecs[i], i);

        // Illegal state 12: strobes all low, recovery with enable low
        enable = 1'b0;
        force dut.state = 4'd12;
        #0;
        release dut.state;
        exp_q.push_back({4'd12, S_NONE});
        idx_q.push_back(1000);
        -> check_ev;
        @(posedge clk);
        #2;
        exp_q.push_back({4'd0, S_IA});
        idx_q.push_back(1001);
        -> check_ev;
        #5;

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Eight-phase control sequencer for the 8-bit accumulator CPU. It steps every instruction through fetch, decode and execute phases and produces the per-phase control strobes that drive the address mux, memory, instruction register, program counter, accumulator and the 8-bit ALU. Opcode comes from the instruction register. The zero flag comes from the ALU `a_is_zero` output. Adds a halted state with explicit resume and a global stall input.

## Interface
- `OPW`, 3, opcode width; fixed encoding below, no other value supported
- `clk` input 1 — system clock, rising edge
- `rst_n` input 1 — asynchronous, active-low reset
- `enable` input 1 — phase advance enable; 0 freezes the sequencer (memory stall)
- `go` input 1 — resume from HALTED; level-sampled
- `opcode` input OPW — current IR opcode: HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111
- `zero` input 1 — accumulator-is-zero flag from the ALU
- `sel` output 1 — address mux: 1=PC, 0=IR operand address
- `rd` output 1 — memory read
- `ld_ir` output 1 — load instruction register
- `inc_pc` output 1 — increment PC
- `halt` output 1 — processor halted indication
- `ld_pc` output 1 — load PC from operand (jump)
- `data_e` output 1 — drive accumulator onto data bus
- `ld_ac` output 1 — load accumulator from ALU output
- `wr` output 1 — memory write
- `phase` output 4 — current state code, for debug and the bench

## Operation
- States, with `phase` code: INST_ADDR 0, INST_FETCH 1, INST_LOAD 2, IDLE 3, OP_ADDR 4, OP_FETCH 5, ALU_OP 6, STORE 7, HALTED 8.
- The state register is the only storage. All control outputs are combinational decodes of the state, `opcode` and `zero`.
- ALUOP = opcode is ADD, AND, XOR or LDA.
- Output decode. Any output not listed is 0.
  - INST_ADDR: sel=1.
  - INST_FETCH: sel=1, rd=1.
  - INST_LOAD: sel=1, rd=1, ld_ir=1.
  - IDLE: sel=1, rd=1, ld_ir=1.
  - OP_ADDR: inc_pc=1, halt=(opcode==HLT).
  - OP_FETCH: rd=ALUOP.
  - ALU_OP: rd=ALUOP, inc_pc=(opcode==SKZ && zero), ld_pc=(opcode==JMP), data_e=(opcode==STO).
  - STORE: rd=ALUOP, ld_ac=ALUOP, ld_pc=(opcode==JMP), wr=(opcode==STO), data_e=(opcode==STO).
  - HALTED: halt=1.
- Transitions are taken on a rising clk edge only when `enable`=1, except where noted.
  - Normal sequence: 0→1→2→3→4→5→6→7→0.
  - OP_ADDR with opcode==HLT → HALTED instead of OP_FETCH.
  - HALTED → OP_FETCH when `go`=1, independent of `enable`. Stay in HALTED while `go`=0.
  - Undefined state codes (9–15) → INST_ADDR on the next edge, regardless of `enable`. All outputs decode as 0 in these codes.
- `enable`=0 holds the state. Outputs stay valid and track `opcode` and `zero` combinationally.
- HLT still increments the PC in OP_ADDR. After resume the rest of the HLT instruction is a no-op: ALUOP=0, so no rd, ld_ac, wr or ld_pc.

## Timing
- Reset: `rst_n`=0 forces INST_ADDR immediately, with no clock needed.
  - Output values during and after reset: sel=1, all other strobes 0, phase=0.
  - First advance happens on the first rising edge after `rst_n` rises with `enable`=1.
- Reset asserted mid-instruction, including in HALTED, aborts the instruction. No partial strobes persist.
- With `enable` held 1, one instruction takes exactly 8 cycles.
  - INST_ADDR is entered every 8th edge.
  - ld_ir is high for 2 cycles, phases 2–3.
  - ld_ac and wr are high for 1 cycle, phase 7.
- SKZ: the skip decision uses `zero` as sampled during ALU_OP (phase 6). inc_pc is asserted in ALU_OP only.
- JMP: ld_pc is high in phases 6 and 7 (2 cycles).
- HLT: halt=1 from OP_ADDR onward.
  - The state enters HALTED on the OP_ADDR edge.
  - halt drops in the cycle OP_FETCH is entered after `go`.
- `go` already high when HALTED is entered: exactly one cycle is spent in HALTED with halt=1.
- A stall inserts whole cycles. N cycles of `enable`=0 extend the instruction to 8+N cycles.

## Test plan
- Reset and free-run: assert `rst_n`=0 mid-phase 5 → phase=0 and sel=1 asynchronously. Release with enable=1 and opcode=ADD → phase sequence 0..7 repeats. rd high in phases 1–3 and 5–7. ld_ac high in phase 7 only.
- STO/JMP decode: opcode=STO → data_e high in phases 6–7, wr high in phase 7 only, rd=0 in phases 5–7. opcode=JMP → ld_pc high in phases 6–7, ld_ac=0.
- SKZ both ways: opcode=SKZ with zero=1 in phase 6 → inc_pc high in phases 4 and 6. With zero=0 → inc_pc high in phase 4 only.
- Halt/resume: opcode=HLT → halt=1 in phase 4, then phase=8 held for 5 cycles with go=0 and all other strobes 0. Pulse go=1 for 1 cycle, asserted with enable=0 → next phase 5, halt=0, instruction completes, next fetch at phase 0.
- Stall: hold enable=0 for 3 cycles while in phase 2 → phase stays 2 and ld_ir stays 1 for 5 cycles total, then the sequence resumes 3,4,…. Toggle opcode during the stall and check that outputs follow the new decode combinationally.
- Illegal state recovery: force the state register to 12 → all strobes 0, phase=0 after 1 edge with enable=0.
